muldiv_issue_ctrl: RTL and testbench
====================================

Name: muldiv_issue_ctrl

Overview:
- Initiator side of the multi-cycle mul/div start/ready handshake. Sits in the EX stage.
- Accepts one HI/LO operation per request from the pipeline and drives start, signed-flag and operands to the multiplier or divider. Waits for ready, commits the 64-bit result into the HI/LO registers, then releases start.
- Stalls the pipeline for the whole operation. Handles flush by draining the unit cleanly.

Parameters:
- DW, 32, operand width; results and HI/LO pair are 2*DW.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid_i  in  1  EX presents an op this cycle
- req_op_i  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NOP
- req_a_i  in  DW  operand a / dividend / MTHI-MTLO source
- req_b_i  in  DW  operand b / divisor
- flush_i  in  1  pipeline flush; abort the current op without commit
- mul_start_o  out  1  start to multiplier
- mul_signed_o  out  1  signed flag to multiplier
- mul_a_o, mul_b_o  out  DW  multiplier operands
- mul_ready_i  in  1  multiplier result valid
- mul_result_i  in  2DW  product
- div_start_o, div_signed_o, div_a_o, div_b_o  out  1/1/DW/DW  same roles for the divider
- div_ready_i  in  1  divider result valid
- div_result_i  in  2DW  {remainder, quotient}
- stall_o  out  1  hold IF/ID/EX
- hi_o, lo_o  out  DW  architectural HI/LO registers
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - hi_o=lo_o=0.
  - All start and signed outputs 0; operand outputs 0.
  - stall_o=0, busy_o=0.
- States: IDLE, RUN, COMMIT, DRAIN.
- IDLE:
  - req_valid_i with MTHI or MTLO and no flush: write hi_o or lo_o = req_a_i at the next edge. No stall; stays in IDLE.
  - req_valid_i with MULT/MULTU/DIV/DIVU and no flush: latch the operands and signed flag (MULT/DIV signed) into the selected unit's operand registers. Assert that unit's start at the next edge and go to RUN.
  - stall_o is asserted combinationally in the request cycle so EX holds.
- RUN:
  - The selected start is held 1 and its operands are held stable. stall_o=1.
  - On the selected ready_i=1: capture the result into a 2DW holding register and go to COMMIT.
  - The ready of the unselected unit is ignored.
- COMMIT (1 cycle):
  - Write hi_o = hold[2DW-1:DW] and lo_o = hold[DW-1:0].
  - Drop start to 0; stall_o=0 this cycle, so the pipeline advances.
  - Return to IDLE. A new request is accepted only from IDLE, so back-to-back ops carry a minimum 1-cycle gap with start=0. The unit needs that cycle to return to free.
- Latency: request cycle + N unit cycles + COMMIT. With a 34-cycle multiplier, stall lasts 35 cycles and HI/LO update at the COMMIT edge.
- Flush:
  - In IDLE: the request is ignored.
  - In RUN: go to DRAIN; HI/LO are never written.
- DRAIN:
  - start stays 1 until ready_i=1, because the unit only clears ready while start is high at its end state.
  - Then drop start, discard the result and go to IDLE.
  - stall_o=0 in DRAIN; busy_o=1. A new request arriving during DRAIN asserts stall_o and is taken once IDLE is reached.
- Flush in COMMIT: the commit still completes, since the op is architecturally retired.
- Simultaneous ready_i and flush_i in RUN: flush wins, result discarded, go to IDLE via DRAIN's exit path in the same cycle, with start dropped next edge.
- Reset mid-op: the controller clears at once, and both units see start=0. The units share rst, so they reset together.
- Only one of mul_start_o / div_start_o is ever 1.

Decomposition:
- Shared package/defines:
  - op encodings (MD_NOP..MD_MTLO)
  - state encodings
  - MulStart/MulStop and ResultReady/NotReady constants already used by the units
- No sub-module. Both unit ports come from one operand/flag register set, steered by a sel_div bit.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> mul_signed_o=1; stall for the full duration; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; start drops the cycle after ready.
- MULTU a=0xFFFFFFFF, b=2 -> hi_o=0x00000001, lo_o=0xFFFFFFFE; div_start_o never 1.
- DIV a=-7, b=2 with model divider -> hi_o=0xFFFFFFFF (rem -1), lo_o=0xFFFFFFFD (quot -3); stall deasserts exactly in COMMIT.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive cycles -> no stall; hi_o/lo_o updated one edge after each request.
- MULT then flush_i at RUN cycle 5 -> start held until ready, then dropped; HI/LO unchanged; next MULTU issues after DRAIN and completes correctly.
- rst pulsed low asynchronously mid-RUN -> all outputs zero immediately, state IDLE; a new MULT after release completes with the correct product.

Source files
------------

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared encodings for the EX-stage HI/LO issue controller and the
// multi-cycle multiplier/divider units it drives.
package muldiv_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DRAIN  = 2'd3
  } md_state_e;

  // Start/ready levels as the multiplier and divider units define them.
  localparam logic MulStart       = 1'b1;
  localparam logic MulStop        = 1'b0;
  localparam logic ResultReady    = 1'b1;
  localparam logic ResultNotReady = 1'b0;

  function automatic logic is_muldiv(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_live(input md_op_e op);
    return (op != MD_NOP) && (op != MD_RSVD);
  endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Start/ready handshake bundle between the issue controller (master) and
// the multiplier/divider pair (slave).
// Handshake: the master raises *_start_o with stable operands and holds it;
// the unit raises *_ready_i with a valid result and keeps it until it sees
// start low; the master drops start the cycle after it observes ready.
interface muldiv_issue_ctrl_if #(parameter int DW = 32);
  logic              mul_start_o;
  logic              mul_signed_o;
  logic [DW-1:0]     mul_a_o;
  logic [DW-1:0]     mul_b_o;
  logic              mul_ready_i;
  logic [2*DW-1:0]   mul_result_i;
  logic              div_start_o;
  logic              div_signed_o;
  logic [DW-1:0]     div_a_o;
  logic [DW-1:0]     div_b_o;
  logic              div_ready_i;
  logic [2*DW-1:0]   div_result_i;

  modport master (
    output mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
    output div_start_o, div_signed_o, div_a_o, div_b_o,
    input  mul_ready_i, mul_result_i, div_ready_i, div_result_i
  );

  modport slave (
    input  mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
    input  div_start_o, div_signed_o, div_a_o, div_b_o,
    output mul_ready_i, mul_result_i, div_ready_i, div_result_i
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage issue controller: launches one mul/div per request, stalls the
// pipeline until the result lands in HI/LO, and drains the unit on flush.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [2:0]        req_op_i,
  input  logic [DW-1:0]     req_a_i,
  input  logic [DW-1:0]     req_b_i,
  input  logic              flush_i,
  muldiv_issue_ctrl_if.master unit,
  output logic              stall_o,
  output logic [DW-1:0]     hi_o,
  output logic [DW-1:0]     lo_o,
  output logic              busy_o,
  output md_state_e         state_o
);

  md_state_e       r_state, w_next_state;
  md_op_e          w_op;
  logic            w_start, w_stall, w_ready;
  logic            w_idle_req, w_accept, w_wr_hi, w_wr_lo;
  logic [2*DW-1:0] w_result, r_hold;
  logic [DW-1:0]   r_a, r_b, r_hi, r_lo;
  logic            r_signed, r_sel_div;

  assign w_op       = md_op_e'(req_op_i);
  assign w_idle_req = (r_state == ST_IDLE) && req_valid_i && !flush_i;
  assign w_accept   = w_idle_req && is_muldiv(w_op);
  assign w_wr_hi    = w_idle_req && (w_op == MD_MTHI);
  assign w_wr_lo    = w_idle_req && (w_op == MD_MTLO);

  // Only the selected unit's ready/result matter; the other one is ignored.
  assign w_ready  = r_sel_div ? unit.div_ready_i  : unit.mul_ready_i;
  assign w_result = r_sel_div ? unit.div_result_i : unit.mul_result_i;

  always_comb begin
    w_next_state = r_state;
    w_start      = MulStop;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_RUN;
          w_stall      = 1'b1;
        end
      end
      ST_RUN: begin
        w_start = MulStart;
        w_stall = 1'b1;
        // A ready that coincides with flush takes the drain exit directly.
        if (flush_i) begin
          w_next_state = (w_ready == ResultReady) ? ST_IDLE : ST_DRAIN;
        end else if (w_ready == ResultReady) begin
          w_next_state = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        // Start stays high so the unit can clear ready from its end state.
        w_start = MulStart;
        w_stall = req_valid_i && !flush_i && is_live(w_op);
        if (w_ready != ResultNotReady) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_sel_div <= 1'b0;
      r_hold    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_accept) begin
        r_a       <= req_a_i;
        r_b       <= req_b_i;
        r_signed  <= (w_op == MD_MULT) || (w_op == MD_DIV);
        r_sel_div <= (w_op == MD_DIV) || (w_op == MD_DIVU);
      end
      if ((r_state == ST_RUN) && !flush_i && (w_ready == ResultReady)) r_hold <= w_result;
      if (r_state == ST_COMMIT) begin
        r_hi <= r_hold[2*DW-1:DW];
        r_lo <= r_hold[DW-1:0];
      end else begin
        if (w_wr_hi) r_hi <= req_a_i;
        if (w_wr_lo) r_lo <= req_a_i;
      end
    end
  end

  assign unit.mul_start_o  = w_start && !r_sel_div;
  assign unit.div_start_o  = w_start && r_sel_div;
  assign unit.mul_signed_o = r_signed && !r_sel_div;
  assign unit.div_signed_o = r_signed && r_sel_div;
  assign unit.mul_a_o      = r_sel_div ? '0 : r_a;
  assign unit.mul_b_o      = r_sel_div ? '0 : r_b;
  assign unit.div_a_o      = r_sel_div ? r_a : '0;
  assign unit.div_b_o      = r_sel_div ? r_b : '0;

  assign stall_o = w_stall;
  assign busy_o  = (r_state != ST_IDLE);
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;
  assign state_o = r_state;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with behavioural multiplier (34
// cycles) and divider (10 cycles) models on the unit interface.
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  localparam int DW    = 32;
  localparam int MUL_N = 34;
  localparam int DIV_N = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic          flush;
  logic          stall_o, busy_o;
  logic [DW-1:0] hi_o, lo_o;
  md_state_e     state_o;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_issue_ctrl_if #(.DW(DW)) bus ();

  muldiv_issue_ctrl #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .flush_i     (flush),
    .unit        (bus),
    .stall_o     (stall_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy_o      (busy_o),
    .state_o     (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Unit models
  function automatic logic [63:0] mul_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (sgn) return longint'($signed(a)) * longint'($signed(b));
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 32'd0) return '1;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  int mcnt, dcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= 0; bus.mul_ready_i <= 1'b0; bus.mul_result_i <= '0;
    end else if (!bus.mul_start_o) begin
      mcnt <= 0; bus.mul_ready_i <= 1'b0;
    end else if (!bus.mul_ready_i) begin
      if (mcnt == MUL_N - 2) begin
        bus.mul_ready_i  <= 1'b1;
        bus.mul_result_i <= mul_model(bus.mul_signed_o, bus.mul_a_o, bus.mul_b_o);
      end else mcnt <= mcnt + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt <= 0; bus.div_ready_i <= 1'b0; bus.div_result_i <= '0;
    end else if (!bus.div_start_o) begin
      dcnt <= 0; bus.div_ready_i <= 1'b0;
    end else if (!bus.div_ready_i) begin
      if (dcnt == DIV_N - 2) begin
        bus.div_ready_i  <= 1'b1;
        bus.div_result_i <= div_model(bus.div_signed_o, bus.div_a_o, bus.div_b_o);
      end else dcnt <= dcnt + 1;
    end
  end

  // Driver / check tasks
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall, input logic exp_signed,
                        input logic is_div, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  stall_cnt;
    bit  start_ok, saw_other;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1;
    chk({tag, "_req_stall"}, 64'(stall_o), 64'd1);
    step();
    req_valid = 1'b0; req_op = 3'd0;
    chk({tag, "_state_run"}, 64'(state_o), 64'(ST_RUN));
    chk({tag, "_signed"}, 64'(is_div ? bus.div_signed_o : bus.mul_signed_o), 64'(exp_signed));
    chk({tag, "_opa"}, 64'(is_div ? bus.div_a_o : bus.mul_a_o), 64'(a));
    chk({tag, "_opb"}, 64'(is_div ? bus.div_b_o : bus.mul_b_o), 64'(b));
    stall_cnt = 1; start_ok = 1'b1; saw_other = 1'b0;
    while (stall_o === 1'b1 && stall_cnt < 200) begin
      stall_cnt++;
      if ((is_div ? bus.div_start_o : bus.mul_start_o) !== 1'b1) start_ok = 1'b0;
      if ((is_div ? bus.mul_start_o : bus.div_start_o) !== 1'b0) saw_other = 1'b1;
      step();
    end
    chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    chk({tag, "_start_held"}, 64'(start_ok), 64'd1);
    chk({tag, "_other_start"}, 64'(saw_other), 64'd0);
    chk({tag, "_state_commit"}, 64'(state_o), 64'(ST_COMMIT));
    chk({tag, "_start_dropped"}, 64'(is_div ? bus.div_start_o : bus.mul_start_o), 64'd0);
    step();
    chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    chk({tag, "_idle"}, 64'(state_o), 64'(ST_IDLE));
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Directed sequence
  initial begin
    int  g;
    bit  start_ok;
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(state_o), 64'(ST_IDLE));
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_starts", 64'({bus.mul_start_o, bus.div_start_o}), 64'd0);
    chk("rst_signed", 64'({bus.mul_signed_o, bus.div_signed_o}), 64'd0);
    chk("rst_ops", 64'({bus.mul_a_o | bus.mul_b_o | bus.div_a_o | bus.div_b_o}), 64'd0);
    chk("rst_stall_busy", 64'({stall_o, busy_o}), 64'd0);
    rst = 1'b1;
    step();

    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, MUL_N + 1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_N + 1, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N + 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // MTHI then MTLO in consecutive cycles
    req_valid = 1'b1; req_op = MD_MTHI; req_a = 32'h1234_5678;
    #1;
    chk("mthi_stall", 64'(stall_o), 64'd0);
    step();
    chk("mthi_hi", 64'(hi_o), 64'h1234_5678);
    chk("mthi_lo_kept", 64'(lo_o), 64'hFFFF_FFFD);
    req_op = MD_MTLO; req_a = 32'h9ABC_DEF0;
    #1;
    chk("mtlo_stall", 64'(stall_o), 64'd0);
    step();
    req_valid = 1'b0; req_op = 3'd0;
    chk("mtlo_lo", 64'(lo_o), 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", 64'(hi_o), 64'h1234_5678);
    chk("mt_idle", 64'(state_o), 64'(ST_IDLE));

    // MULT flushed at RUN cycle 5, new MULTU waits out the drain
    req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd7; req_b = 32'd6;
    step();
    req_valid = 1'b0; req_op = 3'd0;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_state_drain", 64'(state_o), 64'(ST_DRAIN));
    chk("flush_stall", 64'(stall_o), 64'd0);
    chk("flush_busy", 64'(busy_o), 64'd1);
    chk("flush_start_held", 64'(bus.mul_start_o), 64'd1);
    req_valid = 1'b1; req_op = MD_MULTU; req_a = 32'hFFFF_FFFF; req_b = 32'd2;
    #1;
    chk("drain_req_stall", 64'(stall_o), 64'd1);
    g = 0; start_ok = 1'b1;
    while (state_o == ST_DRAIN && g < 200) begin
      if (bus.mul_start_o !== 1'b1) start_ok = 1'b0;
      step();
      g++;
    end
    chk("drain_start_until_ready", 64'(start_ok), 64'd1);
    chk("drain_exit_idle", 64'(state_o), 64'(ST_IDLE));
    chk("drain_start_dropped", 64'(bus.mul_start_o), 64'd0);
    chk("drain_hi_kept", 64'(hi_o), 64'h1234_5678);
    chk("drain_lo_kept", 64'(lo_o), 64'h9ABC_DEF0);
    run_op("multu_after_drain", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_N + 1, 1'b0, 1'b0,
           32'h0000_0001, 32'hFFFF_FFFE);

    // Flush coinciding with ready: straight back to IDLE, no commit
    req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd100; req_b = 32'd7;
    step();
    req_valid = 1'b0; req_op = 3'd0;
    g = 0;
    while (bus.div_ready_i !== 1'b1 && g < 100) begin
      step();
      g++;
    end
    chk("fr_ready_in_run", 64'(state_o), 64'(ST_RUN));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fr_state_idle", 64'(state_o), 64'(ST_IDLE));
    chk("fr_start_dropped", 64'(bus.div_start_o), 64'd0);
    step();
    chk("fr_hi_kept", 64'(hi_o), 64'h0000_0001);
    chk("fr_lo_kept", 64'(lo_o), 64'hFFFF_FFFE);

    // Asynchronous reset mid-RUN
    req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd3; req_b = 32'd4;
    step();
    req_valid = 1'b0; req_op = 3'd0;
    repeat (3) step();
    chk("mid_run_start", 64'(bus.mul_start_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_state", 64'(state_o), 64'(ST_IDLE));
    chk("arst_hilo", 64'({hi_o, lo_o}), 64'd0);
    chk("arst_starts", 64'({bus.mul_start_o, bus.div_start_o}), 64'd0);
    chk("arst_signed", 64'({bus.mul_signed_o, bus.div_signed_o}), 64'd0);
    chk("arst_ops", 64'({bus.mul_a_o, bus.mul_b_o}), 64'd0);
    chk("arst_stall_busy", 64'({stall_o, busy_o}), 64'd0);
    step();
    rst = 1'b1;
    step();
    run_op("mult_after_rst", MD_MULT, 32'hFFFF_FFFE, 32'h4000_0000, MUL_N + 1, 1'b1, 1'b0,
           32'hFFFF_FFFF, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
